sync_fifo_param: RTL and testbench

- Single-clock, parametrised FIFO. Successor to the team's dual-clock FIFO for same-domain buffering.
- Generalises data width and depth.
- Adds selectable first-word-fall-through (FWFT) mode, almost-full and almost-empty thresholds, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags.
- Storage is a register array; no RAM macro.

---
 rtl/sync_fifo_param_if.sv | 34 +++
 rtl/sync_fifo_param.sv | 111 +++++++++++
 tb/tb_sync_fifo_param.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Request/status bundle for sync_fifo_param.
// master drives requests; slave is the FIFO.
interface sync_fifo_param_if #(
  parameter int DATA_BITS  = 10,
  parameter int DEPTH_BITS = 3
);
  logic                  clear;
  logic                  write;
  logic [DATA_BITS-1:0]  input_data;
  logic                  read;
  logic [DATA_BITS-1:0]  output_data;
  logic                  output_valid;
  logic                  empty;
  logic                  almost_empty;
  logic                  full;
  logic                  almost_full;
  logic [DEPTH_BITS:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear, write, input_data, read,
    input  output_data, output_valid, empty,
    input  almost_empty, full, almost_full,
    input  count, overflow, underflow
  );

  modport slave (
    input  clear, write, input_data, read,
    output output_data, output_valid, empty,
    output almost_empty, full, almost_full,
    output count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock register-array FIFO with optional
// first-word-fall-through output, level flags and sticky errors.
module sync_fifo_param #(
  parameter int DATA_BITS          = 10,
  parameter int DEPTH_BITS         = 3,
  parameter int FWFT               = 0,
  parameter int ALMOST_FULL_LEVEL  = 6,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input logic              clk,
  input logic              reset,
  sync_fifo_param_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_C =
    (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] AF_C =
    (DEPTH_BITS+1)'(ALMOST_FULL_LEVEL);
  localparam logic [DEPTH_BITS:0] AE_C =
    (DEPTH_BITS+1)'(ALMOST_EMPTY_LEVEL);

  logic [DATA_BITS-1:0]  mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_BITS-1:0]  dout_q, dout_d;
  logic                  dval_q, dval_d;

  logic empty, full, rd_acc, wr_acc;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == DEPTH_C);
  assign rd_acc = bus.read & ~empty;
  // A full FIFO may take a write only when a read frees the slot.
  assign wr_acc = bus.write & (~full | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    dout_d   = dout_q;
    dval_d   = 1'b0;
    if (bus.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      dout_d   = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        dout_d   = mem_q[rd_ptr_q];
        dval_d   = 1'b1;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      ovf_d = ovf_q | (bus.write & ~wr_acc);
      unf_d = unf_q | (bus.read & ~rd_acc);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
      dval_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
      dval_q   <= dval_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !bus.clear)
      mem_q[wr_ptr_q] <= bus.input_data;
  end

  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (cnt_q <= AE_C);
  assign bus.almost_full  = (cnt_q >= AF_C);
  assign bus.count        = cnt_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

  if (FWFT != 0) begin : g_fwft
    assign bus.output_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.output_valid = ~empty;
  end else begin : g_std
    assign bus.output_data  = dout_q;
    assign bus.output_valid = dval_q;
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: standard-mode and FWFT instances
// driven from one sequence with hand-computed expectations.
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_BITS(10), .DEPTH_BITS(3)) sb ();
  sync_fifo_param_if #(.DATA_BITS(10), .DEPTH_BITS(3)) fb ();

  sync_fifo_param #(.FWFT(0)) u_std (
    .clk(clk), .reset(reset), .bus(sb)
  );
  sync_fifo_param #(.FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .bus(fb)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_wr(input logic [9:0] d);
    sb.write = 1'b1;
    sb.input_data = d;
    cyc();
    sb.write = 1'b0;
  endtask

  task automatic sb_rd(input string tag,
                       input logic [9:0] d);
    sb.read = 1'b1;
    cyc();
    sb.read = 1'b0;
    chk({tag, "_vld"}, 32'(sb.output_valid), 32'd1);
    chk({tag, "_dat"}, 32'(sb.output_data), 32'(d));
  endtask

  task automatic sb_clear();
    sb.clear = 1'b1;
    cyc();
    sb.clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sb.clear = 0; sb.write = 0; sb.read = 0;
    sb.input_data = '0;
    fb.clear = 0; fb.write = 0; fb.read = 0;
    fb.input_data = '0;
    #2;
    chk("rst_cnt",  32'(sb.count), 32'd0);
    chk("rst_emp",  32'(sb.empty), 32'd1);
    chk("rst_ae",   32'(sb.almost_empty), 32'd1);
    chk("rst_full", 32'(sb.full), 32'd0);
    chk("rst_af",   32'(sb.almost_full), 32'd0);
    chk("rst_vld",  32'(sb.output_valid), 32'd0);
    chk("rst_dat",  32'(sb.output_data), 32'd0);
    chk("rst_ovf",  32'(sb.overflow), 32'd0);
    chk("rst_unf",  32'(sb.underflow), 32'd0);
    chk("rst_fvld", 32'(fb.output_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc();

    // 1: fill / drain
    for (int i = 1; i <= 8; i++) begin
      sb_wr(10'(i));
      chk("t1_cnt",  32'(sb.count), 32'(i));
      chk("t1_af",   32'(sb.almost_full), 32'(i >= 6));
      chk("t1_full", 32'(sb.full), 32'(i == 8));
    end
    for (int i = 1; i <= 8; i++) begin
      sb_rd("t1_rd", 10'(i));
      chk("t1_dcnt", 32'(sb.count), 32'(8 - i));
    end
    cyc();
    chk("t1_vld0", 32'(sb.output_valid), 32'd0);
    chk("t1_hold", 32'(sb.output_data), 32'h008);
    chk("t1_emp",  32'(sb.empty), 32'd1);
    chk("t1_ovf",  32'(sb.overflow), 32'd0);
    chk("t1_unf",  32'(sb.underflow), 32'd0);

    // 2: overflow / underflow
    for (int i = 0; i < 8; i++) sb_wr(10'(12'h011 + i));
    sb_wr(10'h3FF);
    chk("t2_ovf", 32'(sb.overflow), 32'd1);
    chk("t2_cnt", 32'(sb.count), 32'd8);
    for (int i = 0; i < 8; i++)
      sb_rd("t2_rd", 10'(12'h011 + i));
    sb.read = 1'b1;
    cyc();
    sb.read = 1'b0;
    chk("t2_unf",  32'(sb.underflow), 32'd1);
    chk("t2_vld",  32'(sb.output_valid), 32'd0);
    chk("t2_hold", 32'(sb.output_data), 32'h018);
    chk("t2_cnt0", 32'(sb.count), 32'd0);
    sb_clear();
    chk("t2_clr_ovf", 32'(sb.overflow), 32'd0);
    chk("t2_clr_unf", 32'(sb.underflow), 32'd0);
    chk("t2_clr_dat", 32'(sb.output_data), 32'd0);

    // 3: simultaneous read and write at full and empty
    for (int i = 0; i < 8; i++) sb_wr(10'(12'h021 + i));
    sb.write = 1'b1; sb.read = 1'b1;
    sb.input_data = 10'h0AA;
    cyc();
    sb.write = 1'b0; sb.read = 1'b0;
    chk("t3_fcnt", 32'(sb.count), 32'd8);
    chk("t3_fovf", 32'(sb.overflow), 32'd0);
    chk("t3_fdat", 32'(sb.output_data), 32'h021);
    for (int i = 1; i < 8; i++)
      sb_rd("t3_rd", 10'(12'h021 + i));
    sb_rd("t3_rdaa", 10'h0AA);
    chk("t3_cnt0", 32'(sb.count), 32'd0);
    sb.write = 1'b1; sb.read = 1'b1;
    sb.input_data = 10'h0BB;
    cyc();
    sb.write = 1'b0; sb.read = 1'b0;
    chk("t3_ecnt", 32'(sb.count), 32'd1);
    chk("t3_eunf", 32'(sb.underflow), 32'd1);
    chk("t3_evld", 32'(sb.output_valid), 32'd0);
    sb_rd("t3_rdbb", 10'h0BB);
    sb_clear();

    // 4: streaming wrap-around at occupancy 3
    for (int i = 0; i < 3; i++) sb_wr(10'(12'h100 + i));
    for (int k = 0; k < 20; k++) begin
      sb.write = 1'b1; sb.read = 1'b1;
      sb.input_data = 10'(12'h103 + k);
      cyc();
      chk("t4_dat", 32'(sb.output_data), 32'(12'h100 + k));
      chk("t4_cnt", 32'(sb.count), 32'd3);
      chk("t4_ae",  32'(sb.almost_empty), 32'd0);
      chk("t4_af",  32'(sb.almost_full), 32'd0);
    end
    sb.write = 1'b0; sb.read = 1'b0;
    for (int i = 0; i < 3; i++)
      sb_rd("t4_tail", 10'(12'h114 + i));
    chk("t4_emp", 32'(sb.empty), 32'd1);

    // 5: FWFT instance
    chk("t5_dat0", 32'(fb.output_data), 32'd0);
    fb.write = 1'b1;
    fb.input_data = 10'h155;
    cyc();
    fb.write = 1'b0;
    chk("t5_dat", 32'(fb.output_data), 32'h155);
    chk("t5_vld", 32'(fb.output_valid), 32'd1);
    cyc();
    chk("t5_keep", 32'(fb.output_data), 32'h155);
    fb.read = 1'b1;
    cyc();
    fb.read = 1'b0;
    chk("t5_pdat", 32'(fb.output_data), 32'd0);
    chk("t5_pemp", 32'(fb.empty), 32'd1);
    chk("t5_pvld", 32'(fb.output_valid), 32'd0);
    fb.write = 1'b1;
    fb.input_data = 10'h0A1;
    cyc();
    fb.input_data = 10'h0A2;
    cyc();
    fb.write = 1'b0;
    fb.read = 1'b1;
    #1;
    chk("t5_h1", 32'(fb.output_data), 32'h0A1);
    cyc();
    chk("t5_h2", 32'(fb.output_data), 32'h0A2);
    cyc();
    fb.read = 1'b0;
    chk("t5_emp2", 32'(fb.empty), 32'd1);

    // 6: clear with write, then async reset
    for (int i = 0; i < 8; i++) sb_wr(10'(12'h031 + i));
    sb_wr(10'h3EE);
    sb.read = 1'b1;
    repeat (3) cyc();
    sb.read = 1'b0;
    chk("t6_cnt5", 32'(sb.count), 32'd5);
    chk("t6_ovf1", 32'(sb.overflow), 32'd1);
    sb.clear = 1'b1;
    sb.write = 1'b1;
    sb.input_data = 10'h3AB;
    cyc();
    sb.clear = 1'b0;
    sb.write = 1'b0;
    chk("t6_ccnt", 32'(sb.count), 32'd0);
    chk("t6_covf", 32'(sb.overflow), 32'd0);
    chk("t6_cunf", 32'(sb.underflow), 32'd0);
    chk("t6_cvld", 32'(sb.output_valid), 32'd0);
    chk("t6_cdat", 32'(sb.output_data), 32'd0);
    sb_wr(10'h040);
    sb_rd("t6_after", 10'h040);
    for (int i = 0; i < 8; i++) sb_wr(10'(12'h051 + i));
    sb_wr(10'h3CC);
    sb.read = 1'b1;
    sb.write = 1'b1;
    sb.input_data = 10'h061;
    fb.write = 1'b1;
    fb.input_data = 10'h077;
    cyc();
    chk("t6_pre_vld", 32'(sb.output_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_r_cnt",  32'(sb.count), 32'd0);
    chk("t6_r_emp",  32'(sb.empty), 32'd1);
    chk("t6_r_ae",   32'(sb.almost_empty), 32'd1);
    chk("t6_r_full", 32'(sb.full), 32'd0);
    chk("t6_r_af",   32'(sb.almost_full), 32'd0);
    chk("t6_r_ovf",  32'(sb.overflow), 32'd0);
    chk("t6_r_vld",  32'(sb.output_valid), 32'd0);
    chk("t6_r_dat",  32'(sb.output_data), 32'd0);
    chk("t6_r_fvld", 32'(fb.output_valid), 32'd0);
    chk("t6_r_fdat", 32'(fb.output_data), 32'd0);
    cyc();
    chk("t6_r_hold", 32'(sb.count), 32'd0);
    sb.read = 1'b0; sb.write = 1'b0;
    fb.write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc();
    chk("t6_post_emp", 32'(sb.empty), 32'd1);
    sb_wr(10'h2A5);
    sb_rd("t6_post_rd", 10'h2A5);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
